// File: rtl/writeback_retire_unit.sv
// Writeback/retire stage: commits up to two results per beat into the register file,
// tracks outstanding writers per register and drives a sticky halt.
module writeback_retire_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = 4,
    parameter int SB_CNT_W   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           claimValidIn,
    input  logic [IDX_W-1:0]               claimRegIn,
    input  logic [IDX_W-1:0]               claimRegSpecialIn,
    input  logic                           claimSpecialValidIn,
    output logic                           claimReadyOut,
    input  logic                           wbValidIn,
    output logic                           wbReadyOut,
    input  logic [ADDR_WIDTH-1:0]          currentRipIn,
    input  logic [IDX_W-1:0]               destRegIn,
    input  logic [IDX_W-1:0]               destRegSpecialIn,
    input  logic                           destRegSpecialValidIn,
    input  logic [DATA_WIDTH-1:0]          aluResultIn,
    input  logic [DATA_WIDTH-1:0]          aluResultSpecialIn,
    input  logic                           killIn,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regFileOut,
    output logic [NUM_REGS-1:0]            regInUseBitMapOut,
    output logic                           retireValidOut,
    output logic [ADDR_WIDTH-1:0]          retiredRipOut,
    output logic [63:0]                    retireCountOut,
    output logic                           killOut,
    output logic                           sbErrorOut
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } stateType;

    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

    stateType stateQ, stateD;

    logic [DATA_WIDTH-1:0] regFile [NUM_REGS];
    logic [SB_CNT_W-1:0]   sbCnt   [NUM_REGS];

    logic                accept;
    logic                claimAccept;
    logic                claimBlocked;
    logic [NUM_REGS-1:0] decMask;
    logic [NUM_REGS-1:0] claimMask;
    logic [NUM_REGS-1:0] incMask;
    logic [NUM_REGS-1:0] underflowMask;

    assign wbReadyOut    = (stateQ == RUN);
    assign killOut       = (stateQ == HALT);
    assign accept        = wbValidIn & wbReadyOut;
    assign claimReadyOut = wbReadyOut & ~claimBlocked;
    assign claimAccept   = claimValidIn & claimReadyOut;
    assign incMask       = claimMask & {NUM_REGS{claimAccept}};

    // Next-state: a committed terminal beat parks the stage in HALT until reset.
    always_comb begin
        stateD = stateQ;
        unique case (1'b1)
            (stateQ == RUN):  if (accept && killIn) stateD = HALT;
            (stateQ == HALT): stateD = HALT;
            default:          stateD = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stateQ <= RUN;
        else        stateQ <= stateD;
    end

    // Build one-hot claim/retire masks; a repeated index collapses to one bit.
    always_comb begin
        decMask   = '0;
        claimMask = '0;
        if (accept) begin
            decMask[destRegIn] = 1'b1;
            if (destRegSpecialValidIn) decMask[destRegSpecialIn] = 1'b1;
        end
        if (claimValidIn) begin
            claimMask[claimRegIn] = 1'b1;
            if (claimSpecialValidIn) claimMask[claimRegSpecialIn] = 1'b1;
        end
    end

    // Saturation / underflow detection per register.
    always_comb begin
        claimBlocked  = 1'b0;
        underflowMask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (claimMask[i] && sbCnt[i] == CNT_MAX && !decMask[i])
                claimBlocked = 1'b1;
            underflowMask[i] = decMask[i] & ~incMask[i] & (sbCnt[i] == '0);
        end
    end

    // Outstanding-writer counters; simultaneous claim and retire cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) sbCnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (incMask[i] && !decMask[i])
                    sbCnt[i] <= sbCnt[i] + SB_CNT_W'(1);
                else if (decMask[i] && !incMask[i] && sbCnt[i] != '0)
                    sbCnt[i] <= sbCnt[i] - SB_CNT_W'(1);
            end
        end
    end

    // Register file: special first, primary last so it wins on a shared index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
        end else if (accept) begin
            if (destRegSpecialValidIn) regFile[destRegSpecialIn] <= aluResultSpecialIn;
            regFile[destRegIn] <= aluResultIn;
        end
    end

    // Retire bookkeeping and sticky scoreboard error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retireValidOut <= 1'b0;
            retiredRipOut  <= '0;
            retireCountOut <= '0;
            sbErrorOut     <= 1'b0;
        end else begin
            retireValidOut <= accept;
            sbErrorOut     <= sbErrorOut | (|underflowMask);
            if (accept) begin
                retiredRipOut  <= currentRipIn;
                retireCountOut <= retireCountOut + 64'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : gFlat
        assign regFileOut[g*DATA_WIDTH +: DATA_WIDTH] = regFile[g];
        assign regInUseBitMapOut[g] = (sbCnt[g] != '0);
    end

endmodule

// File: tb/tb_writeback_retire_unit.sv
// Directed bench for writeback_retire_unit with a cycle-level reference model
// compared every negative edge, plus literal spot checks.
module tb_writeback_retire_unit;

    logic          clk = 1'b0;
    logic          reset;
    logic          claimValid, claimSpecialValid, wbValid, destSpecialValid, kill;
    logic [3:0]    claimReg, claimRegSpecial, destReg, destRegSpecial;
    logic [63:0]   rip, aluRes, aluResSpecial;
    logic          claimReady, wbReady, retireValid, killOut, sbError;
    logic [1023:0] regFileFlat;
    logic [15:0]   inUse;
    logic [63:0]   retiredRip, retireCount;

    int nChecks = 0;
    int nFails  = 0;

    logic [63:0] mReg [16];
    int          mCnt [16];
    logic [63:0] mCount, mRip;
    logic        mKill, mErr, mRetireValid;

    always #5 clk = ~clk;

    writeback_retire_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .claimValidIn         (claimValid),
        .claimRegIn           (claimReg),
        .claimRegSpecialIn    (claimRegSpecial),
        .claimSpecialValidIn  (claimSpecialValid),
        .claimReadyOut        (claimReady),
        .wbValidIn            (wbValid),
        .wbReadyOut           (wbReady),
        .currentRipIn         (rip),
        .destRegIn            (destReg),
        .destRegSpecialIn     (destRegSpecial),
        .destRegSpecialValidIn(destSpecialValid),
        .aluResultIn          (aluRes),
        .aluResultSpecialIn   (aluResSpecial),
        .killIn               (kill),
        .regFileOut           (regFileFlat),
        .regInUseBitMapOut    (inUse),
        .retireValidOut       (retireValid),
        .retiredRipOut        (retiredRip),
        .retireCountOut       (retireCount),
        .killOut              (killOut),
        .sbErrorOut           (sbError)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelClear();
        for (int r = 0; r < 16; r++) begin
            mReg[r] = '0;
            mCnt[r] = 0;
        end
        mCount = '0; mRip = '0; mKill = 1'b0; mErr = 1'b0; mRetireValid = 1'b0;
    endtask

    function automatic bit retiring(input int r);
        return wbValid && !mKill &&
               (destReg == r || (destSpecialValid && destRegSpecial == r));
    endfunction

    function automatic bit expClaimReady();
        if (mKill) return 1'b0;
        if (!claimValid) return 1'b1;
        if (mCnt[claimReg] >= 3 && !retiring(claimReg)) return 1'b0;
        if (claimSpecialValid && mCnt[claimRegSpecial] >= 3 && !retiring(claimRegSpecial))
            return 1'b0;
        return 1'b1;
    endfunction

    // Reference model advances on each rising edge from the stable inputs.
    always @(posedge clk) begin
        bit acc, cOk;
        int d;
        if (!reset) begin
            modelClear();
        end else begin
            acc = wbValid && !mKill;
            cOk = claimValid && expClaimReady();
            for (int r = 0; r < 16; r++) begin
                d = 0;
                if (cOk && (claimReg == r || (claimSpecialValid && claimRegSpecial == r))) d++;
                if (retiring(r)) d--;
                if (d < 0) begin
                    if (mCnt[r] == 0) mErr = 1'b1;
                    else mCnt[r]--;
                end else if (d > 0) begin
                    mCnt[r]++;
                end
            end
            mRetireValid = acc;
            if (acc) begin
                if (destSpecialValid) mReg[destRegSpecial] = aluResSpecial;
                mReg[destReg] = aluRes;
                mCount = mCount + 64'd1;
                mRip   = rip;
                if (kill) mKill = 1'b1;
            end
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        logic [15:0] expUse;
        for (int r = 0; r < 16; r++) begin
            check($sformatf("reg%0d", r), regFileFlat[r*64 +: 64], mReg[r]);
            expUse[r] = (mCnt[r] != 0);
        end
        check("inUse", {48'd0, inUse}, {48'd0, expUse});
        check("retireValid", {63'd0, retireValid}, {63'd0, mRetireValid});
        check("retiredRip", retiredRip, mRip);
        check("retireCount", retireCount, mCount);
        check("killOut", {63'd0, killOut}, {63'd0, mKill});
        check("sbError", {63'd0, sbError}, {63'd0, mErr});
        check("wbReady", {63'd0, wbReady}, {63'd0, !mKill});
        check("claimReady", {63'd0, claimReady}, {63'd0, expClaimReady()});
    end

    task automatic idle();
        claimValid = 0; claimSpecialValid = 0; wbValid = 0; destSpecialValid = 0; kill = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic claim(input logic [3:0] r, input logic sv, input logic [3:0] rs);
        claimValid = 1; claimReg = r; claimSpecialValid = sv; claimRegSpecial = rs;
    endtask

    task automatic wb(input logic [3:0] d, input logic [63:0] res, input logic sv,
                      input logic [3:0] ds, input logic [63:0] resS,
                      input logic [63:0] pc, input logic k);
        wbValid = 1; destReg = d; aluRes = res; destSpecialValid = sv;
        destRegSpecial = ds; aluResSpecial = resS; rip = pc; kill = k;
    endtask

    initial begin
        logic [63:0] cnt;
        idle();
        claimReg = 0; claimRegSpecial = 0; destReg = 0; destRegSpecial = 0;
        rip = 0; aluRes = 0; aluResSpecial = 0;
        modelClear();
        reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        #1 check("resetWbReady", {63'd0, wbReady}, 64'd1);
        check("resetCount", retireCount, 64'd0);

        claim(4'd3, 0, 4'd0); tick(); idle();
        check("claimBit3", {63'd0, inUse[3]}, 64'd1);
        wb(4'd3, 64'hDEAD_BEEF, 0, 4'd0, 64'd0, 64'h40_0000, 0); tick(); idle();
        check("reg3", regFileFlat[3*64 +: 64], 64'hDEAD_BEEF);
        check("retireBit3", {63'd0, inUse[3]}, 64'd0);
        check("count1", retireCount, 64'd1);
        check("pulseHigh", {63'd0, retireValid}, 64'd1);
        tick();
        check("pulseLow", {63'd0, retireValid}, 64'd0);

        claim(4'd5, 1, 4'd5); tick(); idle();
        wb(4'd5, 64'h11, 1, 4'd5, 64'h22, 64'h40_0010, 0); tick(); idle();
        check("reg5Primary", regFileFlat[5*64 +: 64], 64'h11);
        check("bit5Clear", {63'd0, inUse[5]}, 64'd0);
        check("noErrDual", {63'd0, sbError}, 64'd0);

        claim(4'd9, 0, 4'd0); tick(); idle();
        #1 reset = 0;
        modelClear();
        #1 check("rstReg3", regFileFlat[3*64 +: 64], 64'd0);
        check("rstUse", {48'd0, inUse}, 64'd0);
        check("rstCount", retireCount, 64'd0);
        check("rstKill", {63'd0, killOut}, 64'd0);
        tick();
        reset = 1;
        #1 check("relWbReady", {63'd0, wbReady}, 64'd1);

        repeat (3) begin
            claim(4'd7, 0, 4'd0); tick();
        end
        idle();
        check("bit7Set", {63'd0, inUse[7]}, 64'd1);
        claim(4'd7, 0, 4'd0);
        #1 check("satBlock", {63'd0, claimReady}, 64'd0);
        tick();
        claim(4'd7, 0, 4'd0);
        wb(4'd7, 64'h77, 0, 4'd0, 64'd0, 64'h40_0020, 0);
        #1 check("satBypass", {63'd0, claimReady}, 64'd1);
        tick(); idle();
        claim(4'd1, 1, 4'd7);
        #1 check("satSpecial", {63'd0, claimReady}, 64'd0);
        idle();
        repeat (3) begin
            wb(4'd7, 64'h70, 0, 4'd0, 64'd0, 64'h40_0030, 0); tick();
        end
        idle();
        check("bit7Drained", {63'd0, inUse[7]}, 64'd0);
        check("noErrDrain", {63'd0, sbError}, 64'd0);

        wb(4'd2, 64'h2222, 0, 4'd0, 64'd0, 64'h40_0040, 0); tick(); idle();
        check("reg2Under", regFileFlat[2*64 +: 64], 64'h2222);
        check("bit2Zero", {63'd0, inUse[2]}, 64'd0);
        check("errSet", {63'd0, sbError}, 64'd1);
        tick(); tick();
        check("errSticky", {63'd0, sbError}, 64'd1);

        wb(4'd4, 64'h44, 0, 4'd0, 64'd0, 64'h40_0080, 1); tick(); idle();
        check("killRip", retiredRip, 64'h40_0080);
        check("killOut", {63'd0, killOut}, 64'd1);
        check("killWbReady", {63'd0, wbReady}, 64'd0);
        check("killCount", retireCount, 64'd6);
        cnt = retireCount;
        wb(4'd6, 64'h66, 0, 4'd0, 64'd0, 64'h40_0090, 0);
        claim(4'd1, 0, 4'd0);
        #1 check("haltClaim", {63'd0, claimReady}, 64'd0);
        tick(); tick(); idle();
        check("haltNoWrite", regFileFlat[6*64 +: 64], 64'd0);
        check("haltCount", retireCount, cnt);
        check("haltNoPulse", {63'd0, retireValid}, 64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
